// File: rtl/hamming_pkg.sv
// hamming_pkg: shared widths, FSM states and codeword bit positions
// for the round-robin Hamming(7,4) byte scheduler.
package hamming_pkg;
  localparam int CW_W  = 7;
  localparam int NIB_W = 4;
  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;
  localparam int P1_POS = 0;
  localparam int P2_POS = 1;
  localparam int D0_POS = 2;
  localparam int P3_POS = 3;
  localparam int D1_POS = 4;
  localparam int D2_POS = 5;
  localparam int D3_POS = 6;
endpackage

// File: rtl/hamming74_encoder.sv
// hamming74_encoder: combinational Hamming(7,4) encoder, codeword
// layout [p1 p2 d0 p3 d1 d2 d3] on bits 0..6.
module hamming74_encoder
  import hamming_pkg::*;
(
  input  logic [NIB_W-1:0] nib,
  output logic [CW_W-1:0]  cw
);
  always_comb begin
    cw         = '0;
    cw[P1_POS] = nib[0] ^ nib[1] ^ nib[3];
    cw[P2_POS] = nib[0] ^ nib[2] ^ nib[3];
    cw[D0_POS] = nib[0];
    cw[P3_POS] = nib[1] ^ nib[2] ^ nib[3];
    cw[D1_POS] = nib[1];
    cw[D2_POS] = nib[2];
    cw[D3_POS] = nib[3];
  end
endmodule

// File: rtl/hamming74_byte_scheduler.sv
// hamming74_byte_scheduler: round-robin shares one Hamming(7,4) encoder among
// NUM_REQ byte sources, emitting low then high nibble codewords per byte.
module hamming74_byte_scheduler
  import hamming_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 cw_valid,
  input  logic                 cw_ready,
  output logic [CW_W-1:0]      cw_data,
  output logic [ID_W-1:0]      cw_id,
  output logic                 cw_last,
  output logic                 busy
);
  state_t            state;
  logic [ID_W-1:0]   last_grant, g, idx;
  logic              any_valid, grant;
  logic [NIB_W-1:0]  hi_reg, enc_in;
  logic [CW_W-1:0]   enc_out;
  logic [7:0]        sel_byte;

  // Descending offsets so the nearest requester after last_grant wins.
  always_comb begin
    any_valid = 1'b0;
    g         = '0;
    idx       = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        any_valid = 1'b1;
        g         = idx;
      end
    end
  end

  assign grant     = rst_n && any_valid && (state == IDLE || (state == HIGH && cw_ready));
  assign sel_byte  = req_data[{g, 3'b000} +: 8];
  assign req_ready = grant ? (NUM_REQ'(1) << g) : '0;
  assign enc_in    = grant ? sel_byte[NIB_W-1:0] : hi_reg;
  assign busy      = state != IDLE;

  hamming74_encoder u_enc (
    .nib (enc_in),
    .cw  (enc_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      hi_reg     <= '0;
      cw_valid   <= 1'b0;
      cw_data    <= '0;
      cw_id      <= '0;
      cw_last    <= 1'b0;
    end else if (grant) begin
      state      <= LOW;
      last_grant <= g;
      hi_reg     <= sel_byte[7:4];
      cw_valid   <= 1'b1;
      cw_data    <= enc_out;
      cw_id      <= g;
      cw_last    <= 1'b0;
    end else if (state == LOW && cw_ready) begin
      state   <= HIGH;
      cw_data <= enc_out;
      cw_last <= 1'b1;
    end else if (state == HIGH && cw_ready) begin
      state    <= IDLE;
      cw_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_hamming74_byte_scheduler.sv
// tb_hamming74_byte_scheduler: directed stimulus with a codeword scoreboard
// drained by an independent monitor on handshakes.
module tb_hamming74_byte_scheduler;
  localparam int N = 4;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N*8-1:0] req_data = '0;
  logic [N-1:0] req_ready;
  logic         cw_valid, cw_last, busy;
  logic         cw_ready = 1'b0;
  logic [6:0]   cw_data;
  logic [1:0]   cw_id;
  int           checks = 0;
  int           failures = 0;
  logic [9:0]   exp_q[$];
  logic [6:0]   lo_t[N] = '{7'h07, 7'h2A, 7'h7F, 7'h19};
  logic [6:0]   hi_t[N] = '{7'h19, 7'h4B, 7'h1E, 7'h07};

  hamming74_byte_scheduler #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cw_valid  (cw_valid),
    .cw_ready  (cw_ready),
    .cw_data   (cw_data),
    .cw_id     (cw_id),
    .cw_last   (cw_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [6:0] d, input logic [1:0] id, input logic last);
    exp_q.push_back({d, id, last});
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30 && (busy || exp_q.size() != 0); i++) tick();
    chk("idle_busy", busy, 0);
    chk("idle_drain", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && cw_valid && cw_ready) begin
      logic [9:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL cw_unexpected got=%0h want=none", {cw_data, cw_id, cw_last});
      end else begin
        e = exp_q.pop_front();
        if ({cw_data, cw_id, cw_last} !== e) begin
          failures++;
          $display("FAIL cw_data_id_last got=%0h want=%0h", {cw_data, cw_id, cw_last}, e);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    req_valid = '1;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_cw_valid", cw_valid, 0);
    req_valid = '0;
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    chk("post_rst_valid", cw_valid, 0);
    chk("post_rst_data", cw_data, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_ready", req_ready, 0);

    tick();
    req_data[7:0] = 8'hFB;
    req_valid = 4'b0001;
    cw_ready = 1'b1;
    @(negedge clk);
    chk("single_grant", req_ready, 4'b0001);
    push(7'h55, 2'd0, 1'b0);
    push(7'h7F, 2'd0, 1'b1);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("single_ready_low", req_ready, 0);
    tick();
    tick();
    @(negedge clk);
    chk("single_end_valid", cw_valid, 0);
    chk("single_end_busy", busy, 0);

    tick();
    cw_ready = 1'b0;
    req_data[23:16] = 8'h01;
    req_valid = 4'b0100;
    @(negedge clk);
    chk("bp_grant", req_ready, 4'b0100);
    push(7'h07, 2'd2, 1'b0);
    push(7'h00, 2'd2, 1'b1);
    tick();
    req_valid = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_valid", cw_valid, 1);
      chk("bp_hold", {cw_data, cw_id, cw_last}, {7'h07, 2'd2, 1'b0});
      chk("bp_ready", req_ready, 0);
      tick();
    end
    req_valid = '0;
    cw_ready = 1'b1;
    wait_idle();

    req_data[15:8] = 8'h84;
    req_data[31:24] = 8'h12;
    req_valid = 4'b1010;
    @(negedge clk);
    chk("fair_first", req_ready, 4'b1000);
    push(7'h19, 2'd3, 1'b0);
    push(7'h07, 2'd3, 1'b1);
    tick();
    req_valid = 4'b0010;
    @(negedge clk);
    chk("fair_low_ready", req_ready, 0);
    tick();
    @(negedge clk);
    chk("fair_second", req_ready, 4'b0010);
    push(7'h2A, 2'd1, 1'b0);
    push(7'h4B, 2'd1, 1'b1);
    tick();
    req_valid = '0;
    wait_idle();

    req_data[15:8] = 8'h0B;
    req_valid = 4'b0010;
    @(negedge clk);
    chk("ar_grant", req_ready, 4'b0010);
    push(7'h55, 2'd1, 1'b0);
    tick();
    req_valid = '0;
    tick();
    cw_ready = 1'b0;
    @(negedge clk);
    chk("ar_in_high", {cw_valid, cw_last, busy}, 3'b111);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_cw_valid", cw_valid, 0);
    chk("ar_busy", busy, 0);
    chk("ar_drained", exp_q.size(), 0);
    req_data = {8'h12, 8'h3F, 8'h84, 8'h21};
    req_valid = '1;
    cw_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c % 2 == 0) begin
        chk("rr_grant", req_ready, 4'b0001 << ((c / 2) % N));
        push(lo_t[(c / 2) % N], 2'((c / 2) % N), 1'b0);
        push(hi_t[(c / 2) % N], 2'((c / 2) % N), 1'b1);
      end else begin
        chk("rr_gap_ready", req_ready, 0);
      end
      if (c > 0) chk("rr_valid", cw_valid, 1);
      tick();
    end
    req_valid = '0;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hamming74_byte_scheduler.md
Name: hamming74_byte_scheduler

Overview:
- Shares one hamming74_encoder among NUM_REQ byte-wide requesters using round-robin arbitration.
- For each accepted byte, emits two 7-bit codewords: low nibble first, then high nibble. Each codeword carries the requester ID and a last flag.
- Sits between the per-channel byte sources and the channel/serializer stage. The output uses a registered valid/ready stream.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- ID_W, $clog2(NUM_REQ), width of requester ID. Derived; do not override.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NUM_REQ  per-requester byte valid
- req_data  input  NUM_REQ*8  per-requester byte; requester i occupies bits [8i+7:8i]
- req_ready  output  NUM_REQ  one-hot grant; the byte is accepted in the cycle where req_valid[i] && req_ready[i]
- cw_valid  output  1  codeword valid (registered)
- cw_ready  input  1  downstream ready
- cw_data  output  7  codeword, bit layout [p1 p2 d0 p3 d1 d2 d3] as bits [0..6]
- cw_id  output  ID_W  requester that sourced the byte
- cw_last  output  1  0 = low-nibble codeword, 1 = high-nibble codeword
- busy  output  1  state != IDLE

Behaviour:
- Reset (async on rst_n low):
  - state = IDLE; last_grant = NUM_REQ-1, so requester 0 wins first.
  - cw_valid, cw_data, cw_id, cw_last, busy all 0.
  - req_ready is 0 while in reset.
  - A byte in flight is dropped; no partial codeword is emitted after release.
- FSM states: IDLE, LOW, HIGH.
- Arbitration:
  - Search req_valid starting at (last_grant+1) mod NUM_REQ, wrapping; first set bit wins as g.
  - req_ready[g] is combinational and asserted only in a grant cycle. At most one bit is set.
- Grant cycle, in IDLE, or in HIGH with cw_ready=1, when any req_valid is set:
  - Capture the byte's high nibble into hi_reg.
  - last_grant <= g; cw_id <= g.
  - cw_data <= enc(req_data[g][3:0]); cw_last <= 0; cw_valid <= 1.
  - Next state LOW.
- IDLE with no req_valid: hold; cw_valid stays 0.
- LOW: on cw_valid && cw_ready, cw_data <= enc(hi_reg), cw_last <= 1, next state HIGH. Otherwise hold every output.
- HIGH: on cw_ready, either take a back-to-back grant as above, or, with no req_valid, go to IDLE with cw_valid <= 0. Otherwise hold.
- req_ready depends combinationally on cw_ready in HIGH. This is permitted; there is no path from req_valid to cw_* within the same cycle.
- Latency: byte accept to first codeword valid is 1 cycle.
- Throughput: 1 byte per 2 cycles with cw_ready held high; no bubble between bytes.
- Output stability: while cw_valid && !cw_ready, cw_data, cw_id and cw_last are frozen and req_ready is 0.
- Fairness: a continuously valid requester waits at most NUM_REQ-1 bytes.
- Encoding:
  - d0..d3 = nibble[0..3].
  - p1 = d0^d1^d3, p2 = d0^d2^d3, p3 = d1^d2^d3.
  - Purely combinational; the only register is cw_data.
- req_data of non-granted requesters is ignored. A requester may drop req_valid before it is granted.

Decomposition:
- Package hamming_pkg:
  - CW_W = 7, NIB_W = 4
  - state enum {IDLE, LOW, HIGH}
  - codeword bit-position constants
- Sub-module: a single instance of the existing hamming74_encoder. Its data input is muxed: selected request low nibble during grant cycles, hi_reg otherwise.
- Round-robin search is inline; no separate arbiter module.

Test Plan:
- Reset: hold rst_n=0 then release with all req_valid=0 -> cw_valid=0, cw_data=0, req_ready=0, busy=0 indefinitely.
- Single byte: req_valid[0]=1, data 0xFB, cw_ready=1 -> req_ready=4'b0001 for 1 cycle. Then cw_data=7'h55 (id 0, last 0), then 7'h7F (id 0, last 1), then cw_valid=0, busy=0.
- Backpressure: byte 0x01 from req 2, cw_ready=0 for 5 cycles in LOW -> cw_data holds 7'h07 (id 2, last 0), req_ready=0. After cw_ready=1 -> 7'h00 with last 1.
- Round-robin: all four req_valid=1 continuously, cw_ready=1 -> grant order 0,1,2,3,0, one grant every 2 cycles, cw_valid never drops.
- Fairness/wrap: req 2 granted, then req 1 and req 3 both valid -> req 3 granted before req 1.
- Async reset mid-op: assert rst_n=0 in HIGH with cw_ready=0 -> cw_valid clears without a clock edge. After release with all valid -> first grant is req 0.
